// File: rtl/dmem_ctrl.sv
// rtl/dmem_ctrl.sv - byte-wide data memory controller with fixed read latency
//
// Single-ported DEPTH x 8 memory behind a req/ready handshake. Writes commit
// at the accept edge and acknowledge one cycle later. Reads wait RD_LAT edges
// and return data with a one-cycle rvalid pulse. Out-of-range accesses set err.
//
// Ports:
//   clk     in   clock, rising edge
//   RST     in   synchronous active-high reset
//   req     in   request valid
//   we      in   1 = write, 0 = read
//   addr    in   byte address (ADDR_W bits)
//   wdata   in   write data
//   rdata   out  read data, held between read completions
//   ready   out  request can be accepted this cycle
//   rvalid  out  one-cycle pulse, rdata valid
//   wack    out  one-cycle pulse, write committed
//   err     out  last accepted request was out of range

module dmem_ctrl #(
  parameter int ADDR_W = 16,
  parameter int DEPTH  = 4096,
  parameter int RD_LAT = 2
) (
  input  logic              clk,
  input  logic              RST,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [7:0]        wdata,
  output logic [7:0]        rdata,
  output logic              ready,
  output logic              rvalid,
  output logic              wack,
  output logic              err
);

  localparam int              IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // DEPTH may equal 2^ADDR_W, so compare with one extra bit.
  localparam logic [ADDR_W:0] DEPTH_X  = (ADDR_W+1)'(DEPTH);
  localparam logic [1:0]      LAT_INIT = 2'(RD_LAT - 1);

  typedef enum logic {
    IDLE    = 1'b0,
    RD_WAIT = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;

  logic [7:0]        r_mem [0:DEPTH-1];
  logic [ADDR_W-1:0] r_addr;
  logic [1:0]        r_cnt;
  logic [7:0]        r_rdata;
  logic              r_rvalid;
  logic              r_wack;
  logic              r_err;

  logic              w_accept;
  logic              w_in_range;
  logic              w_rd_in_range;
  logic [IDX_W-1:0]  w_wr_idx;
  logic [IDX_W-1:0]  w_rd_idx;

  assign ready         = (r_state == IDLE) && !RST;
  assign w_accept      = req && ready;
  assign w_in_range    = ({1'b0, addr} < DEPTH_X);
  assign w_rd_in_range = ({1'b0, r_addr} < DEPTH_X);
  assign w_wr_idx      = addr[IDX_W-1:0];
  assign w_rd_idx      = r_addr[IDX_W-1:0];

  // Pulses are masked while RST is high so a reset landing in the
  // acknowledge cycle suppresses the pulse rather than letting it leak out.
  assign rvalid = r_rvalid && !RST;
  assign wack   = r_wack && !RST;
  assign rdata  = r_rdata;
  assign err    = r_err;

  always_ff @(posedge clk) begin
    if (RST) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept && !we) begin
          w_state_nxt = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (r_cnt == 2'd0) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Memory contents survive reset; w_accept is already qualified by !RST.
  always_ff @(posedge clk) begin
    if (w_accept && we && w_in_range) begin
      r_mem[w_wr_idx] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      r_rdata  <= 8'h00;
      r_rvalid <= 1'b0;
      r_wack   <= 1'b0;
      r_err    <= 1'b0;
      r_cnt    <= 2'd0;
    end else begin
      r_rvalid <= 1'b0;
      r_wack   <= 1'b0;
      if (w_accept) begin
        r_err <= !w_in_range;
        if (we) begin
          r_wack <= 1'b1;
        end else begin
          r_addr <= addr;
          r_cnt  <= LAT_INIT;
        end
      end else if (r_state == RD_WAIT) begin
        if (r_cnt == 2'd0) begin
          r_rvalid <= 1'b1;
          r_rdata  <= w_rd_in_range ? r_mem[w_rd_idx] : 8'h00;
        end else begin
          r_cnt <= r_cnt - 2'd1;
        end
      end
    end
  end

endmodule
